// File: rtl/chip8_bus_loader.sv
// chip8_bus_loader
// Bus initiator that loads a CHIP-8 ROM image into the Chip8 slave. It pauses
// the core, writes each streamed byte into the memory window from LOAD_BASE
// upward, programs PC, releases the core, and then reads the state register
// back to confirm that the core is running.
// All bus outputs are decoded from the current state and the latched byte
// registers, so every strobe lasts exactly one cycle. Once a synchronous reset
// lands, the loader is in IDLE with a quiet bus.

module chip8_bus_loader #(
  parameter logic [11:0] LOAD_BASE  = 12'h200,
  parameter int unsigned MAX_BYTES  = 3584,
  parameter logic [17:0] MEM_WINDOW = 18'h10000,
  parameter logic [17:0] REG_PC     = 18'h14,
  parameter logic [17:0] REG_STATE  = 18'h16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic        chipselect_o,
  output logic        write_o,
  output logic [17:0] address_o,
  output logic [31:0] writedata_o,
  input  logic [31:0] readdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  // Sequencer states.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PAUSE    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_LOAD_WR  = 3'd3;
  localparam logic [2:0] S_SET_PC   = 3'd4;
  localparam logic [2:0] S_RUN      = 3'd5;
  localparam logic [2:0] S_RD_STATE = 3'd6;
  localparam logic [2:0] S_RD_WAIT  = 3'd7;

  // Count value that marks an image too large for the space above LOAD_BASE.
  localparam logic [11:0] COUNT_LIMIT = 12'(MAX_BYTES);

  // State register values written to the slave.
  localparam logic [31:0] CORE_PAUSED  = 32'h1;
  localparam logic [31:0] CORE_RUNNING = 32'h0;

  // Registered state and its next-state values.
  logic [2:0]  state_q,   state_d;
  logic [11:0] count_q,   count_d;    // bytes written so far
  logic [7:0]  byte_q,    byte_d;     // byte waiting for its write strobe
  logic [11:0] mem_off_q, mem_off_d;  // Chip8 address of that byte
  logic        last_q,    last_d;     // that byte closes the image
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        error_q,   error_d;

  logic        byte_fire;
  logic        overflow;
  logic        verify_bad;

  // Only the two state bits of the read-back are meaningful.
  logic        unused_readdata;
  assign unused_readdata = ^readdata_i[31:2];

  assign byte_fire  = (state_q == S_LOAD) && byte_valid_i;
  assign overflow   = (count_q == COUNT_LIMIT);
  assign verify_bad = (readdata_i[1:0] != 2'b00);

  // Sequencer next-state and status logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    byte_d    = byte_q;
    mem_off_d = mem_off_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: state_d = S_LOAD;

      S_LOAD: begin
        if (byte_fire) begin
          if (overflow) begin
            // The image does not fit. Drop this byte and leave the core paused.
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            byte_d    = byte_data_i;
            mem_off_d = LOAD_BASE + count_q;
            last_d    = byte_last_i;
            state_d   = S_LOAD_WR;
          end
        end
      end

      S_LOAD_WR: begin
        count_d = count_q + 12'd1;
        state_d = last_q ? S_SET_PC : S_LOAD;
      end

      S_SET_PC:   state_d = S_RUN;

      S_RUN:      state_d = S_RD_STATE;

      S_RD_STATE: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        // The read data for the strobe issued last cycle is on the bus now.
        if (verify_bad) begin
          error_d = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State update. A synchronous reset abandons any sequence in progress.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      byte_q    <= '0;
      mem_off_q <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      byte_q    <= byte_d;
      mem_off_q <= mem_off_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Bus and stream handshake decode. Address and data are zero when no strobe is active.
  always_comb begin
    byte_ready_o = 1'b0;
    chipselect_o = 1'b0;
    write_o      = 1'b0;
    address_o    = '0;
    writedata_o  = '0;

    case (state_q)
      S_PAUSE: begin
        chipselect_o = 1'b1;
        write_o      = 1'b1;
        address_o    = REG_STATE;
        writedata_o  = CORE_PAUSED;
      end

      S_LOAD: byte_ready_o = 1'b1;

      S_LOAD_WR: begin
        chipselect_o = 1'b1;
        write_o      = 1'b1;
        address_o    = MEM_WINDOW | {6'b0, mem_off_q};
        writedata_o  = {24'b0, byte_q};
      end

      S_SET_PC: begin
        chipselect_o = 1'b1;
        write_o      = 1'b1;
        address_o    = REG_PC;
        writedata_o  = {20'b0, LOAD_BASE};
      end

      S_RUN: begin
        chipselect_o = 1'b1;
        write_o      = 1'b1;
        address_o    = REG_STATE;
        writedata_o  = CORE_RUNNING;
      end

      S_RD_STATE: begin
        chipselect_o = 1'b1;
        address_o    = REG_STATE;
      end

      default: ;
    endcase
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_chip8_bus_loader.sv
// Testbench for chip8_bus_loader.
// A transaction-level model builds the list of bus strobes that each load must
// produce. A monitor matches every strobe against that list and checks that the
// bus is quiet between strobes. A small slave returns the read-back word one
// cycle after the read strobe and drives junk data on every other cycle.

module tb_chip8_bus_loader;

  localparam int MAX_BYTES = 3584;

  typedef struct packed {
    logic        wr;
    logic [17:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_last_i;
  logic        byte_ready_o;
  logic        chipselect_o;
  logic        write_o;
  logic [17:0] address_o;
  logic [31:0] writedata_o;
  logic [31:0] readdata_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int          total = 0;
  int          bad   = 0;
  int          seen  = 0;
  txn_t        exp_q[$];
  txn_t        log_q[$];
  txn_t        mon_got;
  txn_t        mon_exp;
  logic [31:0] verify_val;
  logic [7:0]  img [0:4095];

  always #5 clk = ~clk;

  chip8_bus_loader dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_last_i  (byte_last_i),
    .byte_ready_o (byte_ready_o),
    .chipselect_o (chipselect_o),
    .write_o      (write_o),
    .address_o    (address_o),
    .writedata_o  (writedata_o),
    .readdata_i   (readdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each strobe must be the next expected transaction. Between strobes the bus must be all zeros.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (chipselect_o) begin
        mon_got = '{wr: write_o, addr: address_o, data: writedata_o};
        seen++;
        log_q.push_back(mon_got);
        if (exp_q.size() == 0) begin
          check("strobe_expected", 64'(mon_got), 64'hDEAD_0000_0000_0000);
        end else begin
          mon_exp = exp_q.pop_front();
          check("bus_txn", 64'(mon_got), 64'(mon_exp));
        end
      end else begin
        check("quiet_bus", 64'({write_o, address_o, writedata_o}), 64'h0);
      end
      if (byte_ready_o) begin
        check("ready_context", 64'({chipselect_o, busy_o}), 64'b01);
      end
    end
  end

  // Slave: the read-back word is valid only in the cycle after the read strobe.
  initial begin
    readdata_i = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (!reset_i && chipselect_o && !write_o) begin
        @(posedge clk);
        #1 readdata_i = verify_val;
        @(posedge clk);
        #1 readdata_i = $urandom | 32'h3;
      end
    end
  end

  // Expected strobe list for one load, computed from the image length and the end-of-image flag.
  task automatic load_model(input int n, input bit last, input logic [31:0] vv, output bit exp_err);
    exp_q.delete();
    exp_err = 1'b0;
    exp_q.push_back(txn_t'{wr: 1'b1, addr: 18'h16, data: 32'h1});
    for (int i = 0; i < n; i++) begin
      if (i == MAX_BYTES) begin
        exp_err = 1'b1;
        break;
      end
      exp_q.push_back(txn_t'{wr: 1'b1, addr: 18'(18'h10200 + i), data: {24'b0, img[i]}});
    end
    if (!exp_err && last) begin
      exp_q.push_back(txn_t'{wr: 1'b1, addr: 18'h14, data: 32'h200});
      exp_q.push_back(txn_t'{wr: 1'b1, addr: 18'h16, data: 32'h0});
      exp_q.push_back(txn_t'{wr: 1'b0, addr: 18'h16, data: 32'h0});
      exp_err = (vv[1:0] != 2'b00);
    end
  endtask

  // Pulse start, then stream n bytes until busy drops. density 0 means random valid; k > 0 means valid one cycle in k.
  task automatic run_seq(input int n, input bit last, input int density, input bit glitch, output int acc);
    int  cyc;
    int  budget;
    bit  fire;
    acc    = 0;
    cyc    = 0;
    budget = n * 8 + 64;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_accepted", 64'({busy_o, done_o, error_o}), 64'b100);
    while (busy_o && cyc < budget) begin
      if (acc < n && (density == 0 ? ($urandom_range(1) == 1) : (cyc % density == 0))) begin
        byte_valid_i = 1'b1;
        byte_data_i  = img[acc];
        byte_last_i  = last && (acc == n - 1);
      end else begin
        byte_valid_i = 1'b0;
        byte_data_i  = 8'($urandom);
        byte_last_i  = 1'($urandom);
      end
      start_i = glitch && ($urandom_range(3) == 0);
      #4;
      fire = byte_valid_i && byte_ready_o;
      @(posedge clk);
      if (fire) acc++;
      @(negedge clk);
      cyc++;
    end
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    start_i      = 1'b0;
    check("seq_in_budget", 64'(busy_o), 64'h0);
  endtask

  task automatic end_checks(input bit exp_err, input int exp_acc, input int acc);
    check("done_flag", 64'(done_o), 64'h1);
    check("error_flag", 64'(error_o), 64'(exp_err));
    check("busy_flag", 64'(busy_o), 64'h0);
    check("all_txn_seen", 64'(exp_q.size()), 64'h0);
    check("bytes_taken", 64'(acc), 64'(exp_acc));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({byte_ready_o, chipselect_o, write_o, address_o, writedata_o,
                     busy_o, done_o, error_o}), 64'h0);
  endtask

  initial begin
    int acc;
    int n;
    bit exp_err;
    int seen0;
    int guard;

    reset_i      = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = '0;
    byte_last_i  = 1'b0;
    verify_val   = 32'h0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_state");
    @(negedge clk);
    reset_i = 1'b0;

    // Directed three-byte image, pinned against literal strobes.
    img[0] = 8'hA2; img[1] = 8'h2A; img[2] = 8'h60;
    log_q.delete();
    load_model(3, 1'b1, verify_val, exp_err);
    run_seq(3, 1'b1, 1, 1'b0, acc);
    end_checks(exp_err, 3, acc);
    check("lit_count", 64'(log_q.size()), 64'd7);
    if (log_q.size() == 7) begin
      check("lit_pause", 64'(log_q[0]), 64'({1'b1, 18'h16, 32'h1}));
      check("lit_mem0", 64'(log_q[1]), 64'({1'b1, 18'h10200, 32'hA2}));
      check("lit_mem1", 64'(log_q[2]), 64'({1'b1, 18'h10201, 32'h2A}));
      check("lit_mem2", 64'(log_q[3]), 64'({1'b1, 18'h10202, 32'h60}));
      check("lit_pc", 64'(log_q[4]), 64'({1'b1, 18'h14, 32'h200}));
      check("lit_run", 64'(log_q[5]), 64'({1'b1, 18'h16, 32'h0}));
      check("lit_read", 64'(log_q[6]), 64'({1'b0, 18'h16, 32'h0}));
    end
    check("lit_error", 64'(error_o), 64'h0);

    // The same image with valid asserted one cycle in three.
    load_model(3, 1'b1, verify_val, exp_err);
    run_seq(3, 1'b1, 3, 1'b0, acc);
    end_checks(exp_err, 3, acc);

    // The read-back reports a paused core.
    verify_val = 32'h1;
    load_model(3, 1'b1, verify_val, exp_err);
    run_seq(3, 1'b1, 1, 1'b0, acc);
    end_checks(exp_err, 3, acc);
    check("lit_verify_error", 64'(error_o), 64'h1);
    verify_val = 32'h0;

    // start pulses during the load must be ignored.
    for (int i = 0; i < 20; i++) img[i] = 8'($urandom);
    load_model(20, 1'b1, verify_val, exp_err);
    run_seq(20, 1'b1, 0, 1'b1, acc);
    end_checks(exp_err, 20, acc);

    // Random images with random pacing and read-back values.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(50, 1);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      verify_val = ($urandom_range(2) == 0) ? $urandom : 32'h0;
      load_model(n, 1'b1, verify_val, exp_err);
      run_seq(n, 1'b1, $urandom_range(3), 1'($urandom), acc);
      end_checks(exp_err, n, acc);
    end
    verify_val = 32'h0;

    // An image one byte too large, with no end flag.
    for (int i = 0; i < MAX_BYTES + 1; i++) img[i] = 8'($urandom);
    log_q.delete();
    load_model(MAX_BYTES + 1, 1'b0, verify_val, exp_err);
    run_seq(MAX_BYTES + 1, 1'b0, 1, 1'b0, acc);
    end_checks(exp_err, MAX_BYTES + 1, acc);
    check("lit_ovf_error", 64'(error_o), 64'h1);
    check("lit_ovf_writes", 64'(log_q.size()), 64'(MAX_BYTES + 1));
    if (log_q.size() > 0) begin
      check("lit_ovf_top_addr", 64'(log_q[log_q.size() - 1].addr), 64'h10FFF);
    end

    // Reset after the second memory write, then a clean full load.
    for (int i = 0; i < 5; i++) img[i] = 8'($urandom);
    load_model(5, 1'b1, verify_val, exp_err);
    seen0 = seen;
    acc   = 0;
    guard = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (seen < seen0 + 3 && guard < 100) begin
      byte_valid_i = 1'b1;
      byte_data_i  = img[acc];
      byte_last_i  = (acc == 4);
      #4;
      if (byte_ready_o) acc++;
      @(negedge clk);
      #1;
      guard++;
    end
    check("reached_second_write", 64'(seen - seen0), 64'd3);
    reset_i = 1'b1;
    @(posedge clk);
    #1 check_outputs_zero("midload_reset");
    exp_q.delete();
    byte_valid_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    seen0 = seen;
    repeat (20) @(negedge clk);
    check("no_strobe_after_reset", 64'(seen - seen0), 64'h0);
    load_model(5, 1'b1, verify_val, exp_err);
    run_seq(5, 1'b1, 2, 1'b0, acc);
    end_checks(exp_err, 5, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
